tinyqv_div: RTL
===============

Name: tinyqv_div

Overview:
Iterative 32-bit integer divider for the TinyQV core, implementing RISC-V DIV, DIVU, REM and REMU. It is the inverse-operation counterpart to the nibble-serial multiplier. Operands are accepted in parallel on a start pulse and processed by a restoring shift-subtract loop. The result is presented both as a 32-bit word and as a counter-selected 4-bit nibble for the core's nibble-serial writeback path.

Parameters:
RADIX_BITS, 1, quotient bits retired per clock; legal values 1 or 2; N = 32/RADIX_BITS iterations.

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle request; accepted only in IDLE or DONE
is_signed  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU; sampled on start
want_rem  input  1  1 = return remainder, 0 = return quotient; sampled on start
dividend  input  32  sampled on start
divisor  input  32  sampled on start
counter  input  3  nibble select for d; nibble k = result[4k+3:4k]
busy  output  1  high while CALC or FIXUP
done  output  1  high in DONE; held until next accepted start or reset
result  output  32  final quotient or remainder; valid while done=1
d  output  4  result nibble selected by counter; 0 when done=0

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; busy=0, done=0, result=0, d=0; all internal registers cleared. Reset mid-operation abandons the divide with no result.
- States: IDLE -> CALC on start; CALC -> FIXUP after N iterations; FIXUP -> DONE; DONE -> CALC on start, else stays in DONE.
- Start accept cycle (edge T): latch |dividend| and |divisor| (magnitudes only when is_signed=1), neg_q = is_signed & (sign(dividend) ^ sign(divisor)), neg_r = is_signed & sign(dividend). Also latch want_rem, the raw dividend and a div0 flag.
- CALC: 33-bit partial remainder register. Each iteration shifts {rem, quo} left by 1, trial-subtracts the divisor, and keeps the difference and sets the quotient LSB if there is no borrow. With RADIX_BITS=2, two such steps are chained combinationally per clock. An iteration counter counts 0..N-1.
- FIXUP: apply conditional two's-complement negation: quotient by neg_q, remainder by neg_r. Select the output by want_rem and register it into result.
- Latency: done=1 on edge T+N+2 (34 cycles at RADIX_BITS=1, 18 at RADIX_BITS=2); busy=1 from T+1 through T+N+1.
- Divide by zero: quotient=0xFFFFFFFF, remainder=original dividend, signedness ignored. No trap.
- Signed overflow (0x80000000 / 0xFFFFFFFF with is_signed=1): quotient=0x80000000, remainder=0. The natural magnitude algorithm must produce this without a special case; verify it explicitly.
- start while busy=1: ignored, no effect on the in-flight operation or operands.
- start while done=1: done and result clear on the accept edge, and a new operation begins.
- d is combinational from result and counter, gated by done.

Optional Feature:
Macro TINYQV_DIV_EARLY_EN.
- Defined: in the accept cycle, if the divisor is zero, or if unsigned magnitude |divisor| > |dividend|, CALC is skipped and FIXUP is entered directly, so done=1 at T+2. The quotient is 0xFFFFFFFF (div0) or 0. The remainder is the dividend, sign-corrected as usual. Normal cases are unchanged.
- Undefined: every operation takes the full N+2 cycles, with data-independent timing.

Test Plan:
- DIVU 100/7, want_rem=0 then 1 -> result 14, then 2; done exactly 34 cycles after start (RADIX_BITS=1); d with counter=0 reads 0xE, then 0x2.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF. REM 7/-2 -> 0x00000001.
- Divide by zero: DIVU 0x1234/0 -> 0xFFFFFFFF; REMU -> 0x00001234; DIV -> 0xFFFFFFFF. With TINYQV_DIV_EARLY_EN, done at T+2.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0x00000000.
- Assert start at busy cycle 5 with different operands -> ignored; the original 100/7 result still appears at T+34.
- Drop rstn at CALC cycle 10 -> busy, done, result and d go 0 immediately. After release, a new DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.

Source files
------------

// File: rtl/tinyqv_div.sv
// Iterative restoring divider for TinyQV (DIV/DIVU/REM/REMU) with a nibble-serial readout.
// Define TINYQV_DIV_EARLY_EN to bypass the loop for divide-by-zero and |divisor| > |dividend|.
module tinyqv_div #(
   parameter int RADIX_BITS = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        is_signed,
   input  logic        want_rem,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic [2:0]  counter,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [3:0]  d
);

   localparam int N = 32 / RADIX_BITS;

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t      state;
   logic [32:0] rem;
   logic [31:0] quo;
   logic [31:0] div_mag;
   logic [31:0] raw_dividend;
   logic        neg_q;
   logic        neg_r;
   logic        want_rem_q;
   logic        div0;
   logic [4:0]  iter;

   logic [31:0] dvd_mag;
   logic [31:0] dvs_mag;
   logic        start_ok;
   logic        skip_calc;
   logic [64:0] step_a;
   logic [64:0] step_b;
   logic [64:0] calc_next;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic [31:0] fix_out;

   // start is a one-cycle request, taken only when no divide is in flight
   // (IDLE or DONE); while busy it is ignored and nothing is back-pressured.
   assign start_ok = start && ((state == IDLE) || (state == DONE));
   assign dvd_mag  = (is_signed && dividend[31]) ? -dividend : dividend;
   assign dvs_mag  = (is_signed && divisor[31])  ? -divisor  : divisor;

`ifdef TINYQV_DIV_EARLY_EN
   assign skip_calc = (divisor == 32'd0) || (dvs_mag > dvd_mag);
`else
   assign skip_calc = 1'b0;
`endif

   // One restoring step: shift {r, q} left, keep r - dv when it does not borrow.
   function automatic logic [64:0] div_step(input logic [32:0] r, input logic [31:0] q,
                                            input logic [31:0] dv);
      logic [32:0] r_sh;
      logic [31:0] q_sh;
      logic [33:0] diff;
      r_sh = {r[31:0], q[31]};
      q_sh = {q[30:0], 1'b0};
      diff = {r, q[31]} - {2'b00, dv};
      if (!diff[33]) begin
         r_sh    = diff[32:0];
         q_sh[0] = 1'b1;
      end
      return {r_sh, q_sh};
   endfunction

   always_comb begin
      step_a    = div_step(rem, quo, div_mag);
      step_b    = div_step(step_a[64:32], step_a[31:0], div_mag);
      calc_next = (RADIX_BITS == 2) ? step_b : step_a;
   end

   // Divide-by-zero overrides the sign fixup: all-ones quotient, untouched dividend.
   always_comb begin
      q_fix = neg_q ? -quo : quo;
      r_fix = neg_r ? -rem[31:0] : rem[31:0];
      if (div0) begin
         q_fix = 32'hFFFF_FFFF;
         r_fix = raw_dividend;
      end
      fix_out = want_rem_q ? r_fix : q_fix;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         rem          <= '0;
         quo          <= '0;
         div_mag      <= '0;
         raw_dividend <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         want_rem_q   <= 1'b0;
         div0         <= 1'b0;
         iter         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
      end else begin
         busy <= (state == CALC) || (state == FIXUP);
         done <= (state == DONE);
         case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  div_mag      <= dvs_mag;
                  raw_dividend <= dividend;
                  neg_q        <= is_signed & (dividend[31] ^ divisor[31]);
                  neg_r        <= is_signed & dividend[31];
                  want_rem_q   <= want_rem;
                  div0         <= (divisor == 32'd0);
                  iter         <= '0;
                  done         <= 1'b0;
                  result       <= '0;
                  if (skip_calc) begin
                     rem   <= {1'b0, dvd_mag};
                     quo   <= '0;
                     state <= FIXUP;
                  end else begin
                     rem   <= '0;
                     quo   <= dvd_mag;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem  <= calc_next[64:32];
               quo  <= calc_next[31:0];
               iter <= iter + 5'd1;
               if (iter == 5'(N - 1)) state <= FIXUP;
            end
            FIXUP: begin
               result <= fix_out;
               state  <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign d = done ? result[{counter, 2'b00} +: 4] : 4'h0;

endmodule
